// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM GHASH engine.
// Vectors use GCM bit order: index 0 is the leftmost (most significant) bit.
package gcm_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam logic [0:BLOCK_W-1] GCM_R = 128'hE1 << 120;

  typedef enum logic [1:0] {
    CmdInit = 2'd0,
    CmdAad  = 2'd1,
    CmdCt   = 2'd2,
    CmdFin  = 2'd3
  } ghash_cmd_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StTag  = 2'd2
  } ghash_state_e;

  typedef enum logic {
    PhAad = 1'b0,
    PhCt  = 1'b1
  } ghash_phase_e;

  typedef struct packed {
    logic [0:BLOCK_W-1] h;
    logic [0:BLOCK_W-1] acc;
    logic [63:0]        aad_len;
    logic [63:0]        ct_len;
    ghash_phase_e       phase;
  } ghash_ctx_t;

  // Zero every byte at or beyond nbytes (nbytes already limited to 1..16).
  function automatic logic [0:BLOCK_W-1] mask_block(input logic [0:BLOCK_W-1] blk,
                                                    input logic [4:0] nbytes);
    logic [0:BLOCK_W-1] m;
    m = blk;
    for (int j = 0; j < BLOCK_W / 8; j++) begin
      if (5'(j) >= nbytes) m[8*j +: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/gcm_ghash_engine_if.sv
// Command/tag bus of the GHASH engine; o_err exists only when GCM_GHASH_ERR_EN is defined.
interface gcm_ghash_engine_if #(
  parameter int unsigned NUM_CH = 4
);
  import gcm_pkg::*;

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               i_valid;
  logic               o_ready;
  ghash_cmd_e         i_cmd;
  logic [CH_W-1:0]    i_ch;
  logic [0:BLOCK_W-1] i_data;
  logic [0:4]         i_nbytes;
  logic               o_tag_valid;
  logic [0:BLOCK_W-1] o_tag;
  logic [CH_W-1:0]    o_tag_ch;
`ifdef GCM_GHASH_ERR_EN
  logic               o_err;

  modport master (
    output i_valid, i_cmd, i_ch, i_data, i_nbytes,
    input  o_ready, o_tag_valid, o_tag, o_tag_ch, o_err
  );
  modport slave (
    input  i_valid, i_cmd, i_ch, i_data, i_nbytes,
    output o_ready, o_tag_valid, o_tag, o_tag_ch, o_err
  );
`else
  modport master (
    output i_valid, i_cmd, i_ch, i_data, i_nbytes,
    input  o_ready, o_tag_valid, o_tag, o_tag_ch
  );
  modport slave (
    input  i_valid, i_cmd, i_ch, i_data, i_nbytes,
    output o_ready, o_tag_valid, o_tag, o_tag_ch
  );
`endif

endinterface

// File: rtl/gcm_gf128_digit_step.sv
// One digit of a GF(2^128) shift-and-add multiply: consumes DIGIT_W multiplier bits MSB-first.
module gcm_gf128_digit_step
  import gcm_pkg::*;
#(
  parameter int unsigned DIGIT_W = 8
) (
  input  logic [0:BLOCK_W-1] i_z,
  input  logic [0:BLOCK_W-1] i_v,
  input  logic [0:DIGIT_W-1] i_digit,
  output logic [0:BLOCK_W-1] o_z,
  output logic [0:BLOCK_W-1] o_v
);

  logic [0:BLOCK_W-1] w_z;
  logic [0:BLOCK_W-1] w_v;

  always_comb begin
    w_z = i_z;
    w_v = i_v;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (i_digit[i]) w_z = w_z ^ w_v;
      w_v = (w_v >> 1) ^ (w_v[BLOCK_W-1] ? GCM_R : '0);
    end
  end

  assign o_z = w_z;
  assign o_v = w_v;

endmodule

// File: rtl/gcm_ghash_engine.sv
// Multi-context GHASH/tag engine: digit-serial multiply-accumulate, length block and tag XOR.
// Define GCM_GHASH_ERR_EN to enable command-order/length checking and the o_err pulse.
module gcm_ghash_engine
  import gcm_pkg::*;
#(
  parameter int unsigned DIGIT_W = 8,
  parameter int unsigned NUM_CH  = 4
) (
  input logic               clk,
  input logic               rst,
  gcm_ghash_engine_if.slave bus
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NMUL  = BLOCK_W / DIGIT_W;
  localparam int unsigned CNT_W = (NMUL > 1) ? $clog2(NMUL) : 1;

  ghash_state_e       r_state;
  ghash_state_e       w_state_next;
  ghash_ctx_t         r_ctx [NUM_CH];
  logic [CNT_W-1:0]   r_cnt;
  logic [CH_W-1:0]    r_ch;
  logic               r_fin;
  logic [0:BLOCK_W-1] r_z;
  logic [0:BLOCK_W-1] r_v;
  logic [0:BLOCK_W-1] r_x;
  logic [0:BLOCK_W-1] r_ek;
  logic [0:BLOCK_W-1] r_tag;
  logic [CH_W-1:0]    r_tag_ch;
  logic               r_tag_valid;

  logic               w_accept;
  logic               w_is_data;
  logic               w_drop;
  logic               w_last;
  logic [4:0]         w_nb_raw;
  logic [4:0]         w_nbytes;
  logic [63:0]        w_len_inc;
  logic [0:BLOCK_W-1] w_blk;
  logic [0:BLOCK_W-1] w_x;
  logic [0:BLOCK_W-1] w_z_next;
  logic [0:BLOCK_W-1] w_v_next;

  assign w_accept  = bus.i_valid && (r_state == StIdle);
  assign w_is_data = (bus.i_cmd == CmdAad) || (bus.i_cmd == CmdCt);
  assign w_nb_raw  = bus.i_nbytes;

`ifdef GCM_GHASH_ERR_EN
  logic [NUM_CH-1:0] r_partial;
  logic              r_err;
  logic              w_partial;

  assign w_nbytes  = w_nb_raw;
  assign w_partial = w_nb_raw < 5'd16;
  // A partial block is only legal as the last block of a phase; CT after AAD opens a new phase.
  assign w_drop = w_is_data &&
                  ((w_nb_raw == 5'd0) || (w_nb_raw > 5'd16) ||
                   ((bus.i_cmd == CmdAad) && (r_ctx[bus.i_ch].phase == PhCt)) ||
                   (w_partial && r_partial[bus.i_ch] &&
                    !((bus.i_cmd == CmdCt) && (r_ctx[bus.i_ch].phase == PhAad))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_partial <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && w_drop;
      if (w_accept && !w_drop) begin
        r_partial[bus.i_ch] <= w_is_data ? w_partial : 1'b0;
      end
    end
  end

  assign bus.o_err = r_err;
`else
  assign w_nbytes = ((w_nb_raw == 5'd0) || (w_nb_raw > 5'd16)) ? 5'd16 : w_nb_raw;
  assign w_drop   = 1'b0;
`endif

  assign w_len_inc = {56'd0, w_nbytes, 3'd0};
  assign w_blk     = mask_block(bus.i_data, w_nbytes);
  assign w_x       = (bus.i_cmd == CmdFin) ?
                     (r_ctx[bus.i_ch].acc ^ {r_ctx[bus.i_ch].aad_len, r_ctx[bus.i_ch].ct_len}) :
                     (r_ctx[bus.i_ch].acc ^ w_blk);
  assign w_last    = (r_cnt == CNT_W'(NMUL - 1));

  gcm_gf128_digit_step #(
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .i_z     (r_z),
    .i_v     (r_v),
    .i_digit (r_x[0:DIGIT_W-1]),
    .o_z     (w_z_next),
    .o_v     (w_v_next)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept && !w_drop && (bus.i_cmd != CmdInit)) w_state_next = StMul;
      StMul:  if (w_last) w_state_next = r_fin ? StTag : StIdle;
      StTag:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_fin       <= 1'b0;
      r_z         <= '0;
      r_v         <= '0;
      r_x         <= '0;
      r_ek        <= '0;
      r_tag       <= '0;
      r_tag_ch    <= '0;
      r_tag_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_ctx[c] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tag_valid <= 1'b0;
      if (w_accept && !w_drop) begin
        r_ch  <= bus.i_ch;
        r_fin <= (bus.i_cmd == CmdFin);
        r_z   <= '0;
        r_v   <= r_ctx[bus.i_ch].h;
        r_x   <= w_x;
        r_ek  <= bus.i_data;
        r_cnt <= '0;
        unique case (bus.i_cmd)
          CmdInit: begin
            r_ctx[bus.i_ch].h       <= bus.i_data;
            r_ctx[bus.i_ch].acc     <= '0;
            r_ctx[bus.i_ch].aad_len <= '0;
            r_ctx[bus.i_ch].ct_len  <= '0;
            r_ctx[bus.i_ch].phase   <= PhAad;
          end
          CmdAad: r_ctx[bus.i_ch].aad_len <= r_ctx[bus.i_ch].aad_len + w_len_inc;
          CmdCt: begin
            r_ctx[bus.i_ch].ct_len <= r_ctx[bus.i_ch].ct_len + w_len_inc;
            r_ctx[bus.i_ch].phase  <= PhCt;
          end
          CmdFin: begin
            // Operand already captured in r_x, so the context can be wiped now.
            r_ctx[bus.i_ch].acc     <= '0;
            r_ctx[bus.i_ch].aad_len <= '0;
            r_ctx[bus.i_ch].ct_len  <= '0;
            r_ctx[bus.i_ch].phase   <= PhAad;
          end
          default: ;
        endcase
      end
      if (r_state == StMul) begin
        r_z   <= w_z_next;
        r_v   <= w_v_next;
        r_x   <= r_x << DIGIT_W;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last && !r_fin) r_ctx[r_ch].acc <= w_z_next;
      end
      if (r_state == StTag) begin
        r_tag       <= r_z ^ r_ek;
        r_tag_ch    <= r_ch;
        r_tag_valid <= 1'b1;
      end
    end
  end

  assign bus.o_ready     = (r_state == StIdle);
  assign bus.o_tag_valid = r_tag_valid;
  assign bus.o_tag       = r_tag;
  assign bus.o_tag_ch    = r_tag_ch;

endmodule

// File: tb/tb_gcm_ghash_engine.sv
// Self-checking bench for gcm_ghash_engine: bit-serial GHASH model feeding an expected-tag queue.
module tb_gcm_ghash_engine;
  import gcm_pkg::*;

  localparam int unsigned DIGIT_W = 8;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int          NMUL    = 128 / DIGIT_W;

  localparam logic [0:127] TC_H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] TC_EK   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] TC_CT   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] TC2_TAG = 128'hab6e47d42cec13bdf53a67b21257bddf;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [0:127]    tag;
    int              cyc;
  } rx_t;
  typedef struct {
    logic [CH_W-1:0] ch;
    logic [0:127]    tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcm_ghash_engine_if #(.NUM_CH(NUM_CH)) bus ();

  gcm_ghash_engine #(
    .DIGIT_W (DIGIT_W),
    .NUM_CH  (NUM_CH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit drop_next = 1'b0;
  rx_t  rxq[$];
  exp_t expq[$];
  logic [0:127] m_h   [NUM_CH];
  logic [0:127] m_acc [NUM_CH];
  logic [63:0]  m_aad [NUM_CH];
  logic [63:0]  m_ct  [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.o_tag_valid) rxq.push_back('{bus.o_tag_ch, bus.o_tag, cyc});

  function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z;
    logic [0:127] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      if (v[127]) v = (v >> 1) ^ 128'he1000000000000000000000000000000;
      else v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_h[c] = '0; m_acc[c] = '0; m_aad[c] = '0; m_ct[c] = '0;
    end
    expq.delete();
  endtask

  // Drive one command, holding it until accepted, then update the reference model.
  task automatic send(input ghash_cmd_e cmd, input int ch, input logic [0:127] data, input int nb);
    int n;
    int ne;
    logic [0:127] ones;
    logic [0:127] keep;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_cmd = cmd; bus.i_ch = CH_W'(ch);
    bus.i_data = data; bus.i_nbytes = 5'(nb);
    n = 0;
    while (!bus.o_ready && n < 1000) begin @(negedge clk); n++; end
    if (!bus.o_ready) begin
      checks++; errors++;
      $display("FAIL send_ready: o_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    acc_cyc = cyc;
    if (drop_next) begin
      drop_next = 1'b0;
      return;
    end
    ne = (nb == 0 || nb > 16) ? 16 : nb;
    ones = '1;
    keep = ~(ones >> (8 * ne));
    case (cmd)
      CmdInit: begin m_h[ch] = data; m_acc[ch] = '0; m_aad[ch] = '0; m_ct[ch] = '0; end
      CmdAad: begin
        m_acc[ch] = gf_mul(m_acc[ch] ^ (data & keep), m_h[ch]);
        m_aad[ch] = m_aad[ch] + 64'(8 * ne);
      end
      CmdCt: begin
        m_acc[ch] = gf_mul(m_acc[ch] ^ (data & keep), m_h[ch]);
        m_ct[ch] = m_ct[ch] + 64'(8 * ne);
      end
      default: begin
        expq.push_back('{CH_W'(ch), gf_mul(m_acc[ch] ^ {m_aad[ch], m_ct[ch]}, m_h[ch]) ^ data});
        m_acc[ch] = '0; m_aad[ch] = '0; m_ct[ch] = '0;
      end
    endcase
  endtask

  task automatic wait_rx(input int k, output bit ok);
    int n;
    n = 0;
    while (rxq.size() < k && n < 400) begin @(negedge clk); n++; end
    ok = (rxq.size() >= k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_tag_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b tag_valid=%b, required 1/0", bus.o_ready, bus.o_tag_valid);
    end
    checks++;
    if (bus.o_tag !== '0 || bus.o_tag_ch !== '0) begin
      errors++;
      $display("FAIL reset_tag: tag=%h ch=%0d, required 0/0", bus.o_tag, bus.o_tag_ch);
    end
`ifdef GCM_GHASH_ERR_EN
    checks++;
    if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: o_err=%b, required 0", bus.o_err); end
`endif
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_tc1();
    rx_t r; exp_t e; bit ok;
    send(CmdInit, 0, TC_H, 16);
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL tc1_init_ready: o_ready=%b, required 1", bus.o_ready); end
    send(CmdFin, 0, TC_EK, 16);
    wait_rx(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tc1_valid: no o_tag_valid seen, required 1 tag"); end
    else begin
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== TC_EK) begin errors++; $display("FAIL tc1_tag: got %h, required %h", r.tag, TC_EK); end
      checks++;
      if (r.tag !== e.tag || r.ch !== e.ch) begin
        errors++; $display("FAIL tc1_model: got %h/%0d, required %h/%0d", r.tag, r.ch, e.tag, e.ch);
      end
      checks++;
      if (r.cyc - acc_cyc !== NMUL + 1) begin
        errors++; $display("FAIL tc1_latency: got %0d, required %0d", r.cyc - acc_cyc, NMUL + 1);
      end
    end
  endtask

  task automatic test_tc2();
    rx_t r; exp_t e; bit ok; int n;
    send(CmdInit, 0, TC_H, 16);
    send(CmdCt, 0, TC_CT, 16);
    checks++;
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL tc2_busy: o_ready=%b, required 0", bus.o_ready); end
    n = 0;
    while (!bus.o_ready && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (cyc - acc_cyc !== NMUL) begin
      errors++; $display("FAIL tc2_ready_lat: got %0d, required %0d", cyc - acc_cyc, NMUL);
    end
    send(CmdFin, 0, TC_EK, 16);
    wait_rx(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tc2_valid: no o_tag_valid seen, required 1 tag"); end
    else begin
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== TC2_TAG) begin errors++; $display("FAIL tc2_tag: got %h, required %h", r.tag, TC2_TAG); end
      checks++;
      if (r.tag !== e.tag) begin errors++; $display("FAIL tc2_model: got %h, required %h", r.tag, e.tag); end
    end
  endtask

  task automatic test_interleave();
    rx_t r; exp_t e; bit ok;
    send(CmdInit, 0, TC_H, 16);
    send(CmdInit, NUM_CH - 1, TC_H, 16);
    send(CmdCt, 0, TC_CT, 16);
    send(CmdCt, NUM_CH - 1, TC_CT, 16);
    send(CmdFin, 0, TC_EK, 16);
    send(CmdFin, NUM_CH - 1, TC_EK, 16);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ilv_valid: got %0d tags, required 2", rxq.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        r = rxq.pop_front(); e = expq.pop_front();
        checks++;
        if (r.tag !== TC2_TAG || r.ch !== e.ch) begin
          errors++;
          $display("FAIL ilv_tag%0d: got %h ch %0d, required %h ch %0d", i, r.tag, r.ch, TC2_TAG, e.ch);
        end
      end
    end
  endtask

  task automatic test_partial();
    rx_t r1; rx_t r2; exp_t e1; exp_t e2; bit ok;
    logic [0:127] d; logic [0:127] h; logic [0:127] ek;
    d = {$urandom(), 96'h0}; h = rnd128(); ek = rnd128();
    send(CmdInit, 1, h, 16);
    send(CmdInit, 2, h, 16);
    send(CmdCt, 1, d | {32'h0, {96{1'b1}}}, 4);
    send(CmdCt, 2, d, 4);
    send(CmdFin, 1, ek, 16);
    send(CmdFin, 2, ek, 16);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL part_valid: got %0d tags, required 2", rxq.size()); end
    else begin
      r1 = rxq.pop_front(); r2 = rxq.pop_front(); e1 = expq.pop_front(); e2 = expq.pop_front();
      checks++;
      if (r1.tag !== e1.tag || r1.ch !== 2'd1) begin
        errors++; $display("FAIL part_ff: got %h ch %0d, required %h ch 1", r1.tag, r1.ch, e1.tag);
      end
      checks++;
      if (r2.tag !== e2.tag || r2.tag !== r1.tag) begin
        errors++; $display("FAIL part_00: got %h, required %h", r2.tag, e2.tag);
      end
    end
  endtask

  task automatic test_reset_mid();
    rx_t r; exp_t e; bit ok;
    send(CmdInit, 0, TC_H, 16);
    send(CmdCt, 0, TC_CT, 16);
    send(CmdFin, 0, TC_EK, 16);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: o_ready=%b, required 1", bus.o_ready); end
    repeat (NMUL + 4) @(negedge clk);
    checks++;
    if (rxq.size() != 0) begin errors++; $display("FAIL rstmid_notag: got %0d tags, required 0", rxq.size()); end
    rxq.delete();
    send(CmdFin, 2, TC_CT, 16);
    send(CmdInit, 0, TC_H, 16);
    send(CmdFin, 0, TC_EK, 16);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_valid: got %0d tags, required 2", rxq.size()); end
    else begin
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== TC_CT || r.tag !== e.tag) begin
        errors++; $display("FAIL rstmid_cleared: got %h, required %h", r.tag, TC_CT);
      end
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== TC_EK || r.ch !== e.ch) begin
        errors++; $display("FAIL rstmid_tc1: got %h, required %h", r.tag, TC_EK);
      end
    end
  endtask

  task automatic test_random();
    rx_t r; exp_t e; bit ok; int ch; int na; int nc;
    for (int it = 0; it < 4; it++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      na = $urandom_range(0, 2);
      nc = $urandom_range(1, 3);
      send(CmdInit, ch, rnd128(), 16);
      for (int i = 0; i < na; i++) send(CmdAad, ch, rnd128(), 16);
      for (int i = 0; i < nc; i++) send(CmdCt, ch, rnd128(), (i == nc - 1) ? $urandom_range(1, 16) : 16);
      send(CmdFin, ch, rnd128(), 16);
      wait_rx(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_valid: no o_tag_valid seen, required 1 tag", it); end
      else begin
        r = rxq.pop_front(); e = expq.pop_front();
        checks++;
        if (r.tag !== e.tag || r.ch !== e.ch) begin
          errors++; $display("FAIL rand%0d_tag: got %h ch %0d, required %h ch %0d", it, r.tag, r.ch, e.tag, e.ch);
        end
      end
    end
  endtask

`ifdef GCM_GHASH_ERR_EN
  task automatic test_err();
    rx_t r; exp_t e; bit ok;
    send(CmdInit, 0, TC_H, 16);
    send(CmdCt, 0, TC_CT, 16);
    drop_next = 1'b1;
    send(CmdAad, 0, TC_CT, 16);
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL err_order: err=%b ready=%b, required 1/1", bus.o_err, bus.o_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.o_err !== 1'b0) begin errors++; $display("FAIL err_pulse: o_err=%b, required 0", bus.o_err); end
    drop_next = 1'b1;
    send(CmdCt, 0, TC_CT, 0);
    checks++;
    if (bus.o_err !== 1'b1) begin errors++; $display("FAIL err_zero: o_err=%b, required 1", bus.o_err); end
    send(CmdFin, 0, TC_EK, 16);
    send(CmdInit, 1, TC_H, 16);
    send(CmdCt, 1, TC_CT, 4);
    drop_next = 1'b1;
    send(CmdCt, 1, TC_CT, 4);
    checks++;
    if (bus.o_err !== 1'b1) begin errors++; $display("FAIL err_partial: o_err=%b, required 1", bus.o_err); end
    send(CmdFin, 1, TC_EK, 16);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_valid: got %0d tags, required 2", rxq.size()); end
    else begin
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== TC2_TAG) begin errors++; $display("FAIL err_tc2: got %h, required %h", r.tag, TC2_TAG); end
      r = rxq.pop_front(); e = expq.pop_front();
      checks++;
      if (r.tag !== e.tag) begin errors++; $display("FAIL err_part_tag: got %h, required %h", r.tag, e.tag); end
    end
  endtask
`else
  task automatic test_nbytes_clamp();
    rx_t r; exp_t e; bit ok;
    send(CmdInit, 0, TC_H, 16);
    send(CmdCt, 0, TC_CT, 0);
    send(CmdFin, 0, TC_EK, 16);
    send(CmdInit, 3, TC_H, 16);
    send(CmdCt, 3, TC_CT, 20);
    send(CmdFin, 3, TC_EK, 16);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clamp_valid: got %0d tags, required 2", rxq.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        r = rxq.pop_front(); e = expq.pop_front();
        checks++;
        if (r.tag !== TC2_TAG || r.tag !== e.tag) begin
          errors++; $display("FAIL clamp_tag%0d: got %h, required %h", i, r.tag, TC2_TAG);
        end
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_cmd = CmdInit; bus.i_ch = '0; bus.i_data = '0; bus.i_nbytes = 5'd16;
    test_reset();
    test_tc1();
    test_tc2();
    test_interleave();
    test_partial();
    test_reset_mid();
    test_random();
`ifdef GCM_GHASH_ERR_EN
    test_err();
`else
    test_nbytes_clamp();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (rxq.size() != 0 || expq.size() != 0) begin
      errors++; $display("FAIL leftover: rx=%0d exp=%0d, required 0/0", rxq.size(), expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
